// File: rtl/mmio_uart_tx_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
package mmio_uart_tx_pkg;

  // Bit of the pipeline's io_cs vector that selects this core.
  localparam int unsigned UART_TX_CORE_IDX = 2;

  // Word offsets (io_addr[7:2]) of the architected registers.
  typedef enum logic [5:0] {
    REG_TXDATA   = 6'h00,
    REG_STATUS   = 6'h01,
    REG_BAUD_DIV = 6'h02,
    REG_CTRL     = 6'h03
  } uart_reg_offset_e;

  // Transmit serialiser states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_tx_state_e;

  // STATUS register layout.
  localparam int unsigned STATUS_FULL_BIT  = 0;
  localparam int unsigned STATUS_EMPTY_BIT = 1;
  localparam int unsigned STATUS_BUSY_BIT  = 2;
  localparam int unsigned STATUS_OVF_BIT   = 3;
  localparam int unsigned STATUS_LEVEL_LSB = 8;

  // CTRL register layout.
  localparam int unsigned CTRL_ENABLE_BIT = 0;
  localparam int unsigned CTRL_IRQ_EN_BIT = 1;

  // Assemble the STATUS word from its individual fields.
  function automatic logic [31:0] pack_status(input logic       full,
                                              input logic       empty,
                                              input logic       busy,
                                              input logic       ovf,
                                              input logic [7:0] level);
    logic [31:0] word;
    word                          = 32'h0000_0000;
    word[STATUS_FULL_BIT]         = full;
    word[STATUS_EMPTY_BIT]        = empty;
    word[STATUS_BUSY_BIT]         = busy;
    word[STATUS_OVF_BIT]          = ovf;
    word[STATUS_LEVEL_LSB +: 8]   = level;
    return word;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// MMIO access bus between the load/store pipeline (master) and an I/O core (slave).
interface mmio_uart_tx_if;
  logic        io_cs;
  logic        io_rd_en;
  logic        io_wr_en;
  logic [7:0]  io_addr;
  logic [31:0] io_wr_data;
  logic [3:0]  io_wr_strobe;
  logic [31:0] io_rd_data;
  logic        io_rd_valid;

  modport master (
    output io_cs, io_rd_en, io_wr_en, io_addr, io_wr_data, io_wr_strobe,
    input  io_rd_data, io_rd_valid
  );

  modport slave (
    input  io_cs, io_rd_en, io_wr_en, io_addr, io_wr_data, io_wr_strobe,
    output io_rd_data, io_rd_valid
  );
endinterface

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; a pop in the same cycle lets a
// push into a full FIFO succeed.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push_s, do_pop_s;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level     = wr_ptr_q - rd_ptr_q;
  assign pop_data  = mem_q[rd_ptr_q[AW-1:0]];
  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push & (~full | do_pop_s);

  // Advance the pointers for accepted pushes and pops.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end
endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: register file, TX FIFO, baud timer
// and serialiser FSM.
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH       = 16,
  parameter logic [15:0] DEFAULT_BAUD_DIV = 16'd867
) (
  input  logic           clk,
  input  logic           rst_n,
  mmio_uart_tx_if.slave  bus,
  output logic           uart_tx,
  output logic           tx_irq
);
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  // Bus decode.
  logic        rd_acc_s, wr_acc_s;
  logic [5:0]  reg_off_s;
  logic [31:0] rd_word_s;

  // Architected registers.
  logic [15:0] baud_div_q, baud_div_d;
  logic        ctrl_en_q, ctrl_en_d;
  logic        irq_en_q, irq_en_d;
  logic        ovf_q, ovf_d;
  logic        ovf_clr_s;
  logic [31:0] rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic        irq_q, irq_d;

  // FIFO interface.
  logic          push_s, pop_s;
  logic [7:0]    fifo_dout_s;
  logic          fifo_full_s, fifo_empty_s;
  logic [LW-1:0] fifo_level_s;

  // Serialiser.
  uart_tx_state_e state_q, state_d;
  logic [15:0]    baud_cnt_q, baud_cnt_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           tx_q, tx_d;
  logic           bit_end_s, can_start_s, busy_s;

  assign rd_acc_s    = bus.io_cs & bus.io_rd_en;
  assign wr_acc_s    = bus.io_cs & bus.io_wr_en;
  assign reg_off_s   = bus.io_addr[7:2];
  assign busy_s      = (state_q != ST_IDLE);
  assign bit_end_s   = (baud_cnt_q == 16'd0);
  assign can_start_s = ctrl_en_q & ~fifo_empty_s;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .push_data (bus.io_wr_data[7:0]),
    .pop       (pop_s),
    .pop_data  (fifo_dout_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .level     (fifo_level_s)
  );

  // Register writes: TXDATA push, overflow clear, BAUD_DIV bytes, CTRL bits.
  always_comb begin
    baud_div_d = baud_div_q;
    ctrl_en_d  = ctrl_en_q;
    irq_en_d   = irq_en_q;
    ovf_clr_s  = 1'b0;
    push_s     = 1'b0;
    if (wr_acc_s) begin
      case (reg_off_s)
        REG_TXDATA: push_s = bus.io_wr_strobe[0];
        REG_STATUS: ovf_clr_s = bus.io_wr_strobe[0] & bus.io_wr_data[STATUS_OVF_BIT];
        REG_BAUD_DIV: begin
          if (bus.io_wr_strobe[0]) begin
            baud_div_d[7:0] = bus.io_wr_data[7:0];
          end else begin
            baud_div_d[7:0] = baud_div_q[7:0];
          end
          if (bus.io_wr_strobe[1]) begin
            baud_div_d[15:8] = bus.io_wr_data[15:8];
          end else begin
            baud_div_d[15:8] = baud_div_q[15:8];
          end
        end
        REG_CTRL: begin
          if (bus.io_wr_strobe[0]) begin
            ctrl_en_d = bus.io_wr_data[CTRL_ENABLE_BIT];
            irq_en_d  = bus.io_wr_data[CTRL_IRQ_EN_BIT];
          end else begin
            ctrl_en_d = ctrl_en_q;
            irq_en_d  = irq_en_q;
          end
        end
        default: push_s = 1'b0;
      endcase
    end else begin
      push_s = 1'b0;
    end
  end

  // Sticky overflow: a dropped push sets it, a write-one clears it.
  always_comb begin
    ovf_d = ovf_q;
    if (push_s && fifo_full_s && !pop_s) begin
      ovf_d = 1'b1;
    end else if (ovf_clr_s) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Read mux over pre-write state; unmapped and write-only offsets read zero.
  always_comb begin
    rd_word_s = 32'h0000_0000;
    case (reg_off_s)
      REG_STATUS:   rd_word_s = pack_status(fifo_full_s, fifo_empty_s, busy_s, ovf_q,
                                            8'(fifo_level_s));
      REG_BAUD_DIV: rd_word_s = {16'h0000, baud_div_q};
      REG_CTRL:     rd_word_s = {30'h0000_0000, irq_en_q, ctrl_en_q};
      default:      rd_word_s = 32'h0000_0000;
    endcase
  end

  // Read response: capture on an accepted read, otherwise hold the last data.
  always_comb begin
    rd_valid_d = rd_acc_s;
    if (rd_acc_s) begin
      rd_data_d = rd_word_s;
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  // Interrupt level: enabled, nothing queued and the serialiser idle.
  always_comb begin
    irq_d = irq_en_q & fifo_empty_s & ~busy_s;
  end

  // Register file and bus response flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_div_q <= DEFAULT_BAUD_DIV;
      ctrl_en_q  <= 1'b0;
      irq_en_q   <= 1'b0;
      ovf_q      <= 1'b0;
      rd_data_q  <= 32'h0000_0000;
      rd_valid_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      baud_div_q <= baud_div_d;
      ctrl_en_q  <= ctrl_en_d;
      irq_en_q   <= irq_en_d;
      ovf_q      <= ovf_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      irq_q      <= irq_d;
    end
  end

  // Serialiser next state: the line value is computed for the coming cycle so
  // the output pin is a flop; every bit start reloads the baud counter.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    pop_s      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (can_start_s) begin
          pop_s      = 1'b1;
          shift_d    = fifo_dout_s;
          state_d    = ST_START;
          tx_d       = 1'b0;
          baud_cnt_d = baud_div_q;
        end else begin
          state_d    = ST_IDLE;
          tx_d       = 1'b1;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          state_d    = ST_DATA;
          bit_cnt_d  = 3'd0;
          tx_d       = shift_q[0];
          baud_cnt_d = baud_div_q;
        end else begin
          baud_cnt_d = baud_cnt_q - 16'd1;
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          baud_cnt_d = baud_div_q;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end else begin
          baud_cnt_d = baud_cnt_q - 16'd1;
        end
      end
      ST_STOP: begin
        if (bit_end_s) begin
          if (can_start_s) begin
            pop_s      = 1'b1;
            shift_d    = fifo_dout_s;
            state_d    = ST_START;
            tx_d       = 1'b0;
            baud_cnt_d = baud_div_q;
          end else begin
            state_d    = ST_IDLE;
            tx_d       = 1'b1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // Serialiser state; reset drives the line high immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      baud_cnt_q <= 16'd0;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
    end
  end

  assign uart_tx         = tx_q;
  assign tx_irq          = irq_q;
  assign bus.io_rd_data  = rd_data_q;
  assign bus.io_rd_valid = rd_valid_q;
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: register reads and serial line
// cycles are checked against expectations queued as the stimulus is issued.
module tb_mmio_uart_tx;
  import mmio_uart_tx_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       uart_tx;
  logic       tx_irq;
  logic [3:0] cs_vec;

  int checks;
  int errors;

  logic [31:0] exp_q[$];
  logic        tx_exp_q[$];

  mmio_uart_tx_if bus ();
  assign bus.io_cs = cs_vec[UART_TX_CORE_IDX];

  mmio_uart_tx #(
    .FIFO_DEPTH       (16),
    .DEFAULT_BAUD_DIV (16'd867)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .uart_tx (uart_tx),
    .tx_irq  (tx_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // All bus tasks start and end at a falling edge.
  task automatic bus_idle();
    cs_vec           = 4'h0;
    bus.io_rd_en     = 1'b0;
    bus.io_wr_en     = 1'b0;
    bus.io_addr      = 8'h00;
    bus.io_wr_data   = 32'h0;
    bus.io_wr_strobe = 4'h0;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic cs);
    cs_vec                   = 4'h0;
    cs_vec[UART_TX_CORE_IDX] = cs;
    bus.io_wr_en             = 1'b1;
    bus.io_addr              = a;
    bus.io_wr_data           = d;
    bus.io_wr_strobe         = s;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic bus_read(input logic [7:0] a, input logic cs,
                          output logic [31:0] d, output logic v);
    cs_vec                   = 4'h0;
    cs_vec[UART_TX_CORE_IDX] = cs;
    bus.io_rd_en             = 1'b1;
    bus.io_addr              = a;
    @(negedge clk);
    d = bus.io_rd_data;
    v = bus.io_rd_valid;
    bus_idle();
  endtask

  task automatic apply_reset();
    bus_idle();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] d, e;
    logic v;
    apply_reset();
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", uart_tx); end
    checks++; if (tx_irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", tx_irq); end
    checks++; if (bus.io_rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", bus.io_rd_valid); end
    checks++; if (bus.io_rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data: got %h expected 0", bus.io_rd_data); end
    exp_q.push_back(32'h0000_0002);
    bus_read(8'h04, 1'b1, d, v);
    e = exp_q.pop_front();
    checks++; if (v !== 1'b1) begin errors++; $display("FAIL reset_status_valid: got %b expected 1", v); end
    checks++; if (d !== e) begin errors++; $display("FAIL reset_status: got %h expected %h", d, e); end
    @(negedge clk);
    checks++; if (bus.io_rd_valid !== 1'b0) begin errors++; $display("FAIL rd_valid_pulse: got %b expected 0", bus.io_rd_valid); end
    checks++; if (bus.io_rd_data !== e) begin errors++; $display("FAIL rd_data_hold: got %h expected %h", bus.io_rd_data, e); end
    exp_q.push_back(32'd867);
    bus_read(8'h08, 1'b1, d, v);
    e = exp_q.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL reset_baud: got %h expected %h", d, e); end
  endtask

  task automatic test_single_frame();
    logic [31:0] d, e;
    logic v, et;
    logic [9:0] fr;
    int waited;
    bus_write(8'h08, 32'd3, 4'hF, 1'b1);
    bus_write(8'h0C, 32'd3, 4'h1, 1'b1);
    bus_write(8'h00, 32'h5A, 4'h1, 1'b1);
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL sf_pre_idle: got %b expected 1", uart_tx); end
    waited = 0;
    while (uart_tx !== 1'b0 && waited < 20) begin @(negedge clk); waited++; end
    checks++; if (waited !== 1) begin errors++; $display("FAIL sf_start_latency: got %0d expected 1", waited); end
    fr = {1'b1, 8'h5A, 1'b0};
    for (int b = 0; b < 10; b++) repeat (4) tx_exp_q.push_back(fr[b]);
    for (int i = 0; i < 40; i++) begin
      et = tx_exp_q.pop_front();
      checks++; if (uart_tx !== et) begin errors++; $display("FAIL sf_tx cycle %0d: got %b expected %b", i, uart_tx, et); end
      if (i == 20) begin
        checks++; if (tx_irq !== 1'b0) begin errors++; $display("FAIL sf_irq_busy: got %b expected 0", tx_irq); end
      end
      exp_q.push_back(32'h0000_0006);
      bus_read(8'h04, 1'b1, d, v);
      e = exp_q.pop_front();
      checks++; if (d !== e) begin errors++; $display("FAIL sf_busy cycle %0d: got %h expected %h", i, d, e); end
    end
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL sf_post_tx: got %b expected 1", uart_tx); end
    exp_q.push_back(32'h0000_0002);
    bus_read(8'h04, 1'b1, d, v);
    e = exp_q.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL sf_done_status: got %h expected %h", d, e); end
    checks++; if (tx_irq !== 1'b1) begin errors++; $display("FAIL sf_irq_done: got %b expected 1", tx_irq); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, e;
    logic v, et;
    logic [19:0] fr;
    int waited;
    bus_write(8'h0C, 32'd0, 4'h1, 1'b1);
    bus_write(8'h08, 32'd0, 4'hF, 1'b1);
    bus_write(8'h00, 32'h01, 4'h1, 1'b1);
    bus_write(8'h00, 32'h80, 4'h1, 1'b1);
    bus_write(8'h0C, 32'd1, 4'h1, 1'b1);
    waited = 0;
    while (uart_tx !== 1'b0 && waited < 20) begin @(negedge clk); waited++; end
    checks++; if (waited !== 1) begin errors++; $display("FAIL b2b_start_latency: got %0d expected 1", waited); end
    fr = {1'b1, 8'h80, 1'b0, 1'b1, 8'h01, 1'b0};
    for (int b = 0; b < 20; b++) tx_exp_q.push_back(fr[b]);
    for (int i = 0; i < 20; i++) begin
      et = tx_exp_q.pop_front();
      checks++; if (uart_tx !== et) begin errors++; $display("FAIL b2b_tx cycle %0d: got %b expected %b", i, uart_tx, et); end
      @(negedge clk);
    end
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL b2b_post_tx: got %b expected 1", uart_tx); end
    exp_q.push_back(32'h0000_0002);
    bus_read(8'h04, 1'b1, d, v);
    e = exp_q.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL b2b_status: got %h expected %h", d, e); end
  endtask

  task automatic test_cs_gating();
    logic [31:0] d, e;
    logic v, stayed_high;
    bus_write(8'h00, 32'h41, 4'h1, 1'b0);
    stayed_high = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (uart_tx !== 1'b1) stayed_high = 1'b0;
      @(negedge clk);
    end
    checks++; if (stayed_high !== 1'b1) begin errors++; $display("FAIL cs_tx_idle: got %b expected 1", stayed_high); end
    exp_q.push_back(32'h0000_0002);
    bus_read(8'h04, 1'b1, d, v);
    e = exp_q.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL cs_level: got %h expected %h", d, e); end
    exp_q.push_back(32'h0);
    bus_read(8'h10, 1'b1, d, v);
    e = exp_q.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL unmapped_read: got %h expected %h", d, e); end
    exp_q.push_back(32'h0);
    bus_read(8'h00, 1'b1, d, v);
    e = exp_q.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL txdata_read: got %h expected %h", d, e); end
    bus_read(8'h08, 1'b0, d, v);
    checks++; if (v !== 1'b0) begin errors++; $display("FAIL cs_read_valid: got %b expected 0", v); end
    bus_write(8'h08, 32'h0000_AB00, 4'b0010, 1'b1);
    bus_write(8'h08, 32'hFFFF_12CD, 4'b0001, 1'b1);
    exp_q.push_back(32'h0000_ABCD);
    bus_read(8'h08, 1'b1, d, v);
    e = exp_q.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL baud_strobes: got %h expected %h", d, e); end
    // Simultaneous read and write of CTRL: the read sees the old value.
    exp_q.push_back(32'h0000_0001);
    cs_vec[UART_TX_CORE_IDX] = 1'b1;
    bus.io_rd_en = 1'b1; bus.io_wr_en = 1'b1; bus.io_addr = 8'h0C;
    bus.io_wr_data = 32'h2; bus.io_wr_strobe = 4'h1;
    @(negedge clk);
    d = bus.io_rd_data;
    bus_idle();
    e = exp_q.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL rdwr_pre_write: got %h expected %h", d, e); end
    exp_q.push_back(32'h0000_0002);
    bus_read(8'h0C, 1'b1, d, v);
    e = exp_q.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL rdwr_post_write: got %h expected %h", d, e); end
    bus_write(8'h0C, 32'd0, 4'h1, 1'b1);
  endtask

  task automatic test_disable_mid_frame();
    logic [31:0] d, e;
    logic v, et, stayed_high;
    logic [9:0] fr;
    int waited;
    bus_write(8'h08, 32'd1, 4'hF, 1'b1);
    bus_write(8'h00, 32'hC3, 4'h1, 1'b1);
    bus_write(8'h00, 32'h55, 4'h1, 1'b1);
    bus_write(8'h0C, 32'd1, 4'h1, 1'b1);
    waited = 0;
    while (uart_tx !== 1'b0 && waited < 20) begin @(negedge clk); waited++; end
    checks++; if (waited !== 1) begin errors++; $display("FAIL dis_start_latency: got %0d expected 1", waited); end
    fr = {1'b1, 8'hC3, 1'b0};
    for (int b = 0; b < 10; b++) repeat (2) tx_exp_q.push_back(fr[b]);
    for (int i = 0; i < 20; i++) begin
      et = tx_exp_q.pop_front();
      checks++; if (uart_tx !== et) begin errors++; $display("FAIL dis_tx cycle %0d: got %b expected %b", i, uart_tx, et); end
      if (i == 8) bus_write(8'h0C, 32'd0, 4'h1, 1'b1);
      else @(negedge clk);
    end
    stayed_high = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (uart_tx !== 1'b1) stayed_high = 1'b0;
      @(negedge clk);
    end
    checks++; if (stayed_high !== 1'b1) begin errors++; $display("FAIL dis_hold_idle: got %b expected 1", stayed_high); end
    exp_q.push_back(32'h0000_0100);
    bus_read(8'h04, 1'b1, d, v);
    e = exp_q.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL dis_level: got %h expected %h", d, e); end
  endtask

  task automatic test_overflow();
    logic [31:0] d, e;
    logic v;
    int waited;
    // Restart the queued byte, then reset during its start bit.
    bus_write(8'h0C, 32'd1, 4'h1, 1'b1);
    waited = 0;
    while (uart_tx !== 1'b0 && waited < 20) begin @(negedge clk); waited++; end
    checks++; if (uart_tx !== 1'b0) begin errors++; $display("FAIL rst_frame_start: got %b expected 0", uart_tx); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL async_reset_tx: got %b expected 1", uart_tx); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 17; i++) bus_write(8'h00, 32'(i + 16), 4'h1, 1'b1);
    exp_q.push_back(32'h0000_1009);
    bus_read(8'h04, 1'b1, d, v);
    e = exp_q.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL ovf_status: got %h expected %h", d, e); end
    bus_write(8'h04, 32'h8, 4'b0010, 1'b1);
    exp_q.push_back(32'h0000_1009);
    bus_read(8'h04, 1'b1, d, v);
    e = exp_q.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL ovf_no_strobe: got %h expected %h", d, e); end
    bus_write(8'h04, 32'h8, 4'b0001, 1'b1);
    exp_q.push_back(32'h0000_1001);
    bus_read(8'h04, 1'b1, d, v);
    e = exp_q.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL ovf_clear: got %h expected %h", d, e); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus_idle();
    @(negedge clk);
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_cs_gating();
    test_disable_mid_frame();
    test_overflow();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter. An I/O core that answers the uncached MMIO accesses issued by the load/store pipeline.
- The pipeline drives one registered access per cycle: rd_en/wr_en, a per-core chip-select, address, write data and byte strobes. The block responds with registered read data.
- Written bytes are buffered in a TX FIFO and serialised 8N1 on a single output pin. The bit rate comes from a programmable divider.

Parameters:
- FIFO_DEPTH, 16, TX FIFO entries; power of two, at least 2.
- DEFAULT_BAUD_DIV, 16'd867, reset value of BAUD_DIV (100 MHz / 115200 − 1).

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous, active-low reset.
- io_cs  in  1  chip-select for this core (one bit of the pipeline's io_cs vector).
- io_rd_en  in  1  read request; valid only when io_cs=1.
- io_wr_en  in  1  write request; valid only when io_cs=1.
- io_addr  in  8  byte offset within this core's 0x100 page; bits [1:0] ignored.
- io_wr_data  in  32  write data, lane-aligned.
- io_wr_strobe  in  4  byte enables for io_wr_data.
- io_rd_data  out  32  read data, registered.
- io_rd_valid  out  1  pulses one cycle after an accepted read.
- uart_tx  out  1  serial output, idle high.
- tx_irq  out  1  level: CTRL.irq_en and FIFO empty and shifter idle.

Behaviour:
- Register map (word offsets):
  - 0x00 TXDATA: write-only. A write with strobe[0]=1 pushes wr_data[7:0]. Reads return 0.
  - 0x04 STATUS: bit0 full, bit1 empty, bit2 busy (shifter active), bit3 overflow (sticky), bits[15:8] FIFO level. Writing 1 to bit3 (strobe[0]=1) clears overflow.
  - 0x08 BAUD_DIV: bits[15:0], read/write, per-byte strobes honoured.
  - 0x0C CTRL: bit0 enable, bit1 irq_en, read/write.
  - Other offsets: reads return 0, writes are ignored.
- Accesses with io_cs=0 are ignored. rd_en and wr_en together in one cycle: the write is performed and the read returns pre-write state.
- Read latency is exactly 1 cycle. io_rd_data holds its last value when io_rd_valid=0. No stall or backpressure is ever generated.
- Reset values: uart_tx=1, io_rd_data=0, io_rd_valid=0, tx_irq=0, FIFO empty, overflow=0, BAUD_DIV=DEFAULT_BAUD_DIV, CTRL=0, FSM=IDLE.
- FIFO:
  - Pointers are log2(FIFO_DEPTH)+1 bits, with a wrap bit for full/empty.
  - Push when full: data dropped, overflow set.
  - Push and pop in the same cycle when full: the pop frees a slot and the push is accepted.
  - Push when empty is visible to the FSM the next cycle.
- Baud counter:
  - 16-bit down-counter loaded with BAUD_DIV at each bit start; bit period = BAUD_DIV+1 cycles.
  - BAUD_DIV changes take effect at the next bit boundary.
  - BAUD_DIV=0 gives one cycle per bit.
- FSM:
  - IDLE: uart_tx=1. If enable and not empty, pop into the shift register and go to START.
  - START: uart_tx=0 for one bit period, then DATA.
  - DATA: 8 bits LSB first, tracked by a 3-bit bit counter. After bit 7, go to STOP.
  - STOP: uart_tx=1 for one bit period. Then, if enable and not empty, pop the next byte and go straight to START (back-to-back frames with no idle gap); otherwise go to IDLE.
- Clearing enable mid-frame completes the current frame, then the FSM holds in IDLE. FIFO contents are retained.
- busy = (state != IDLE).
- Asserting rst_n low mid-frame forces uart_tx=1 immediately, asynchronously, and the frame is lost.

Decomposition:
- Shared package: uart_reg_offset_e (TXDATA/STATUS/BAUD_DIV/CTRL), uart_tx_state_e (IDLE/START/DATA/STOP), STATUS bit-position localparams, and the core index constant for io_cs bit selection.
- Sub-module: sync_fifo, parameterised on width and depth, exposing push/pop/full/empty/level. Reusable by a future RX core.

Test Plan:
- Reset: after rst_n rises, uart_tx=1; a STATUS read returns 0x0000_0002 one cycle later with io_rd_valid=1; BAUD_DIV reads 867.
- Single frame: BAUD_DIV=3, CTRL=1, write 0x5A. uart_tx sequence in 4-cycle bits is 0,0,1,0,1,1,0,1,0,1. busy stays high for 40 cycles, then empty=1.
- Back-to-back: BAUD_DIV=0, FIFO holds 0x01 and 0x80. There are exactly 20 cycles between the first start bit and the second stop bit, with no idle cycle in between.
- Overflow: with CTRL=0, write 17 bytes at FIFO_DEPTH=16. STATUS reads full=1, overflow=1, level=16. Writing 0x8 to STATUS clears overflow; full stays 1.
- Disable mid-frame: clear enable during DATA bit 3 with 2 bytes queued. The frame completes, uart_tx stays 1 afterwards, and level=1.
- Chip-select gating: a write of 0x41 to TXDATA with io_cs=0 leaves level=0 and uart_tx idle. A read of offset 0x10 returns 0.
